// File: rtl/ras_spec_ctrl_if.sv
// rtl/ras_spec_ctrl_if.sv - fetch request / prediction channel of the RAS speculation controller
interface ras_spec_ctrl_if #(
  parameter int XLEN = 32
);
  logic            req_valid_i;
  logic            req_ready_o;
  logic [1:0]      req_type_i;
  logic [XLEN-1:0] req_addr_i;
  logic            pred_valid_o;
  logic [XLEN-1:0] pred_addr_o;

  modport master (
    output req_valid_i, req_type_i, req_addr_i,
    input  req_ready_o, pred_valid_o, pred_addr_o
  );

  modport slave (
    input  req_valid_i, req_type_i, req_addr_i,
    output req_ready_o, pred_valid_o, pred_addr_o
  );
endinterface

// File: rtl/ras_spec_ctrl.sv
// rtl/ras_spec_ctrl.sv - RAS speculation controller: serializes stack traffic, logs and unwinds speculative ops
// Optional statistics counters enabled by defining RAS_CTRL_STATS_EN.
module ras_spec_ctrl #(
  parameter int XLEN      = 32,
  parameter int LOG_DEPTH = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  ras_spec_ctrl_if.slave  req,
  input  logic            commit_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            ras_push_o,
  output logic            ras_pop_o,
  output logic [XLEN-1:0] ras_data_o,
  input  logic [XLEN-1:0] ras_top_i,
  input  logic            ras_empty_i
`ifdef RAS_CTRL_STATS_EN
  ,
  output logic [31:0]     stat_pred_o,
  output logic [31:0]     stat_flush_o
`endif
);
  localparam int PW = $clog2(LOG_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(LOG_DEPTH);

  localparam logic [1:0] K_NOP     = 2'b00;
  localparam logic [1:0] K_PUSH    = 2'b01;
  localparam logic [1:0] K_POP     = 2'b10;
  localparam logic [1:0] K_POPPUSH = 2'b11;

  typedef enum logic [1:0] {IDLE, PUSH2, UNWIND} state_t;

  state_t          state;
  logic [PW-1:0]   head;
  logic [CW-1:0]   count;
  logic            uw_second;
  logic [XLEN-1:0] push2_addr;

  logic [1:0]      log_kind  [LOG_DEPTH];
  logic [XLEN-1:0] log_saved [LOG_DEPTH];

  logic [PW-1:0]   tail_idx, young_idx;
  logic [1:0]      young_kind, new_kind;
  logic [XLEN-1:0] young_saved;
  logic            log_empty, log_full, commit_eff, accept, pop_req, relabel;
  logic [CW-1:0]   count_after_commit;

  assign tail_idx           = head + PW'(count);
  assign young_idx          = tail_idx - PW'(1);
  assign young_kind         = log_kind[young_idx];
  assign young_saved        = log_saved[young_idx];
  assign log_empty          = (count == '0);
  assign log_full           = (count == FULL);
  assign commit_eff         = commit_i && !log_empty && (state != UNWIND);
  assign count_after_commit = count - CW'(commit_eff);

  assign req.req_ready_o  = (state == IDLE) && !log_full && !flush_i && !rst_i;
  assign accept           = req.req_valid_i && req.req_ready_o;
  assign pop_req          = accept && req.req_type_i[1] && !ras_empty_i;
  assign req.pred_valid_o = pop_req;
  assign req.pred_addr_o  = pop_req ? ras_top_i : '0;
  assign busy_o           = (state != IDLE);

  // A cancelled coroutine only needs its pop undone; an empty-stack coroutine did nothing.
  assign relabel = (state == PUSH2) && flush_i && (count_after_commit != '0);

  always_comb begin
    new_kind = K_NOP;
    case (req.req_type_i)
      2'b01:   new_kind = K_PUSH;
      2'b10:   new_kind = ras_empty_i ? K_NOP  : K_POP;
      2'b11:   new_kind = ras_empty_i ? K_PUSH : K_POPPUSH;
      default: new_kind = K_NOP;
    endcase
  end

  always_comb begin
    ras_push_o = 1'b0;
    ras_pop_o  = 1'b0;
    ras_data_o = '0;
    case (state)
      IDLE: begin
        ras_pop_o = pop_req;
        if (accept && req.req_type_i == 2'b01) begin
          ras_push_o = 1'b1;
          ras_data_o = req.req_addr_i;
        end
      end
      PUSH2: begin
        if (!flush_i) begin
          ras_push_o = 1'b1;
          ras_data_o = push2_addr;
        end
      end
      UNWIND: begin
        if (!log_empty) begin
          case (young_kind)
            K_PUSH: ras_pop_o = 1'b1;
            K_POP: begin
              ras_push_o = 1'b1;
              ras_data_o = young_saved;
            end
            K_POPPUSH: begin
              if (uw_second) begin
                ras_push_o = 1'b1;
                ras_data_o = young_saved;
              end else begin
                ras_pop_o = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  // Log payload needs no reset: entries are only read below count.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      log_kind[tail_idx]  <= new_kind;
      log_saved[tail_idx] <= ras_top_i;
    end else if (relabel) begin
      log_kind[young_idx] <= (young_kind == K_POPPUSH) ? K_POP : K_NOP;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      head       <= '0;
      count      <= '0;
      uw_second  <= 1'b0;
      push2_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          head      <= head + PW'(commit_eff);
          count     <= count_after_commit + CW'(accept);
          uw_second <= 1'b0;
          if (flush_i && count_after_commit != '0) begin
            state <= UNWIND;
          end else if (accept && req.req_type_i == 2'b11) begin
            state      <= PUSH2;
            push2_addr <= req.req_addr_i;
          end
        end
        PUSH2: begin
          head      <= head + PW'(commit_eff);
          count     <= count_after_commit;
          uw_second <= 1'b0;
          state     <= relabel ? UNWIND : IDLE;
        end
        UNWIND: begin
          if (log_empty) begin
            state <= IDLE;
          end else if (young_kind == K_POPPUSH && !uw_second) begin
            uw_second <= 1'b1;
          end else begin
            uw_second <= 1'b0;
            count     <= count - CW'(1);
            if (count == CW'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RAS_CTRL_STATS_EN
  logic flush_unwinds;
  assign flush_unwinds = flush_i && (state != UNWIND) && (count_after_commit != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_pred_o  <= '0;
      stat_flush_o <= '0;
    end else begin
      if (pop_req && stat_pred_o != '1)        stat_pred_o  <= stat_pred_o + 32'd1;
      if (flush_unwinds && stat_flush_o != '1) stat_flush_o <= stat_flush_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ras_spec_ctrl.sv
// tb/tb_ras_spec_ctrl.sv - directed self-checking bench for ras_spec_ctrl with a behavioural stack model
module tb_ras_spec_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        commit_i, flush_i;
  logic        busy_o, ras_push_o, ras_pop_o, ras_empty_i;
  logic [31:0] ras_data_o, ras_top_i;

  int tests = 0;
  int fails = 0;

  ras_spec_ctrl_if #(.XLEN(32)) rif ();

  ras_spec_ctrl #(.XLEN(32), .LOG_DEPTH(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req         (rif.slave),
    .commit_i    (commit_i),
    .flush_i     (flush_i),
    .busy_o      (busy_o),
    .ras_push_o  (ras_push_o),
    .ras_pop_o   (ras_pop_o),
    .ras_data_o  (ras_data_o),
    .ras_top_i   (ras_top_i),
    .ras_empty_i (ras_empty_i)
  );

  always #5 clk_i = ~clk_i;

  // Stack model that the controller drives.
  logic [31:0] stk [16];
  int sp = 0;
  int n_push = 0;
  int n_pop = 0;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sp <= 0;
    end else if (ras_push_o) begin
      stk[4'(sp)] <= ras_data_o;
      sp          <= sp + 1;
      n_push      <= n_push + 1;
    end else if (ras_pop_o) begin
      sp    <= sp - 1;
      n_pop <= n_pop + 1;
    end
  end

  assign ras_empty_i = (sp == 0);
  assign ras_top_i   = (sp == 0) ? 32'd0 : stk[4'(sp - 1)];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic quiet();
    rif.req_valid_i = 1'b0;
    rif.req_type_i  = 2'b00;
    rif.req_addr_i  = 32'd0;
    commit_i        = 1'b0;
    flush_i         = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    quiet();
    #1;
  endtask

  task automatic drive_req(input logic [1:0] t, input logic [31:0] a);
    rif.req_valid_i = 1'b1;
    rif.req_type_i  = t;
    rif.req_addr_i  = a;
    #1;
  endtask

  int snap_pop, cyc;

  initial begin
    rst_i = 1'b1;
    quiet();
    #3;
    chk("rst_ready", 32'(rif.req_ready_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_strobes", {30'd0, ras_push_o, ras_pop_o}, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    chk("ready_after_rst", 32'(rif.req_ready_o), 32'd1);

    drive_req(2'b01, 32'h100);
    chk("call_a_push", {30'd0, ras_push_o, ras_pop_o}, 32'd2);
    chk("call_a_data", ras_data_o, 32'h100);
    tick();
    drive_req(2'b01, 32'h200);
    tick();
    drive_req(2'b10, 32'h0);
    chk("ret1_pred_valid", 32'(rif.pred_valid_o), 32'd1);
    chk("ret1_pred_addr", rif.pred_addr_o, 32'h200);
    chk("ret1_strobes", {30'd0, ras_push_o, ras_pop_o}, 32'd1);
    tick();
    drive_req(2'b10, 32'h0);
    chk("ret2_pred_addr", rif.pred_addr_o, 32'h100);
    tick();
    for (int i = 0; i < 4; i++) begin
      commit_i = 1'b1;
      tick();
    end

    drive_req(2'b10, 32'h0);
    chk("ret_empty_pred", 32'(rif.pred_valid_o), 32'd0);
    chk("ret_empty_strobes", {30'd0, ras_push_o, ras_pop_o}, 32'd0);
    tick();
    flush_i = 1'b1;
    #1;
    chk("flush_ready_low", 32'(rif.req_ready_o), 32'd0);
    tick();
    chk("nop_unwind_busy", 32'(busy_o), 32'd1);
    chk("nop_unwind_strobes", {30'd0, ras_push_o, ras_pop_o}, 32'd0);
    tick();
    chk("nop_unwind_done", 32'(busy_o), 32'd0);

    drive_req(2'b01, 32'h100);
    tick();
    commit_i = 1'b1;
    tick();
    drive_req(2'b11, 32'h300);
    chk("co_c1_pop", {30'd0, ras_push_o, ras_pop_o}, 32'd1);
    chk("co_c1_pred", rif.pred_addr_o, 32'h100);
    tick();
    chk("co_c2_ready", 32'(rif.req_ready_o), 32'd0);
    chk("co_c2_push", {30'd0, ras_push_o, ras_pop_o}, 32'd2);
    chk("co_c2_data", ras_data_o, 32'h300);
    tick();
    flush_i = 1'b1;
    tick();
    chk("co_uw1_pop", {30'd0, ras_push_o, ras_pop_o}, 32'd1);
    tick();
    chk("co_uw2_push", {30'd0, ras_push_o, ras_pop_o}, 32'd2);
    chk("co_uw2_data", ras_data_o, 32'h100);
    tick();
    chk("co_uw_done", 32'(busy_o), 32'd0);
    chk("co_uw_top", ras_top_i, 32'h100);
    chk("co_uw_depth", 32'(sp), 32'd1);

    drive_req(2'b11, 32'h400);
    chk("p2f_c1_pred", rif.pred_addr_o, 32'h100);
    tick();
    flush_i = 1'b1;
    #1;
    chk("p2f_no_push", {30'd0, ras_push_o, ras_pop_o}, 32'd0);
    tick();
    chk("p2f_uw_push", {30'd0, ras_push_o, ras_pop_o}, 32'd2);
    chk("p2f_uw_data", ras_data_o, 32'h100);
    tick();
    chk("p2f_done", 32'(busy_o), 32'd0);
    chk("p2f_depth", 32'(sp), 32'd1);

    for (int i = 0; i < 8; i++) begin
      drive_req(2'b01, 32'h10 * 32'(i + 1));
      tick();
    end
    chk("full_ready_low", 32'(rif.req_ready_o), 32'd0);
    snap_pop = n_pop;
    commit_i = 1'b1;
    flush_i  = 1'b1;
    tick();
    cyc = 0;
    while (busy_o && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("full_unwind_cycles", 32'(cyc), 32'd7);
    chk("full_unwind_pops", 32'(n_pop - snap_pop), 32'd7);
    chk("full_unwind_top", ras_top_i, 32'h10);

    drive_req(2'b00, 32'h55);
    chk("illegal_ready", 32'(rif.req_ready_o), 32'd1);
    chk("illegal_strobes", {30'd0, ras_push_o, ras_pop_o}, 32'd0);
    tick();
    commit_i = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      drive_req(2'b01, 32'h1000 + 32'(i));
      tick();
    end
    chk("full2_ready_low", 32'(rif.req_ready_o), 32'd0);
    commit_i = 1'b1;
    tick();
    chk("commit_ready_high", 32'(rif.req_ready_o), 32'd1);
    flush_i = 1'b1;
    tick();
    tick();
    tick();
    chk("pre_rst_busy", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("rst_uw_busy", 32'(busy_o), 32'd0);
    chk("rst_uw_strobes", {30'd0, ras_push_o, ras_pop_o}, 32'd0);
    chk("rst_uw_data", ras_data_o, 32'd0);
    chk("rst_uw_ready", 32'(rif.req_ready_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    chk("rst_rel_ready", 32'(rif.req_ready_o), 32'd1);
    flush_i = 1'b1;
    tick();
    chk("rst_log_empty", 32'(busy_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
